alu_muldiv: RTL
===============

# alu_muldiv

Iterative multiply/divide unit holding the MIPS32 HI/LO register pair, parametrised in operand width. It sits beside the single-cycle ALU in the execute stage and serves MULT, MULTU, DIV, DIVU, MTHI and MTLO. The decode stage stalls on `busy`, and MFHI/MFLO read `hi`/`lo` directly. Multiplication uses radix-2 shift-add and division uses restoring shift-subtract; both work on operand magnitudes and apply a sign fix-up at the end.

## Interface
- `WIDTH`, default 32: operand, HI and LO width; must be at least 4.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `start` in 1: request a new operation; sampled on the rising edge.
- `op` in 2: operation select. 00 = MULT, 01 = MULTU, 10 = DIV, 11 = DIVU.
- `a` in WIDTH: rs operand (multiplicand or dividend).
- `b` in WIDTH: rt operand (multiplier or divisor).
- `wr_hi` in 1: MTHI strobe.
- `wr_lo` in 1: MTLO strobe.
- `wdata` in WIDTH: data for MTHI/MTLO.
- `busy` out 1: an operation is in flight; decode stalls while it is high.
- `done` out 1: one-cycle pulse; `hi`/`lo` hold the result during this cycle.
- `div_by_zero` out 1: qualifies `done`; high when a DIV/DIVU had `b` = 0.
- `hi` out WIDTH: HI register (upper product / remainder).
- `lo` out WIDTH: LO register (lower product / quotient).

## Operation
- States:
  - IDLE -> CALC when `start` is high.
  - CALC -> FIX after WIDTH iterations.
  - FIX -> IDLE unconditionally.
- Accepting an operation (IDLE with `start` high):
  - latch `op`;
  - latch |a| and |b|; magnitudes are taken only for signed ops, where the two's-complement negation of the most negative value is read as unsigned 2^(WIDTH-1);
  - latch the sign bits;
  - clear the iteration counter.
- CALC, multiply: each cycle, if the multiplier LSB is 1, add the multiplicand to the upper half of the 2·WIDTH accumulator (keeping the carry), then shift right by one.
- CALC, divide: each cycle, shift the remainder left, bring in the next dividend bit, trial-subtract the divisor; if the result is non-negative, keep it and set the quotient bit to 1.
- FIX, sign correction and register write:
  - MULT: negate the 2·WIDTH product if sign(a) ≠ sign(b).
  - DIV: negate the quotient if sign(a) ≠ sign(b); the remainder takes the sign of `a` (truncating division).
  - Write `hi` (upper product / remainder) and `lo` (lower product / quotient).
- Divide by zero (DIV or DIVU with `b` = 0):
  - same latency as a normal divide;
  - `lo` = all ones, `hi` = `a` as originally presented;
  - `div_by_zero` = 1 together with `done`.
- Signed overflow (DIV of the most negative value by −1): `lo` = 2^(WIDTH-1), `hi` = 0. This falls out of the magnitude datapath; no special case is needed.
- MTHI/MTLO:
  - `wr_hi`/`wr_lo` write `wdata` on the edge only when `busy` is 0; they are ignored while `busy` is 1, including the FIX cycle.
  - A write may coincide with an accepted `start`: the write lands now and the result overwrites it later.
- `start` while `busy` is high: ignored, no queueing.
- Reset values: state IDLE; `busy` = 0, `done` = 0, `div_by_zero` = 0, `hi` = 0, `lo` = 0; counter and all datapath registers 0.
- Asserting `rst_n` mid-operation aborts the operation immediately; no `done` is produced.

## Timing
- `start` is accepted at edge k; `busy` rises after edge k.
- CALC iterations occur at edges k+1 … k+WIDTH.
- FIX occurs at edge k+WIDTH+1. After it, `hi`/`lo` are updated, `done` = 1 for one cycle, and `busy` = 0.
- Latency is WIDTH+1 edges from accept to result (33 for WIDTH = 32).
- Back-to-back: a `start` sampled in the `done` cycle is accepted, since the state is already IDLE.
- `done` and `div_by_zero` are registered and deassert on the following edge.
- `hi` and `lo` are registered and hold between writes.

## Configuration
- `ALU_MULDIV_DIV_EN` defined: full behaviour as above.
- `ALU_MULDIV_DIV_EN` undefined: the divider datapath is removed. DIV/DIVU behave as follows:
  - they are accepted;
  - they go directly to FIX with no CALC cycles;
  - `done` pulses after edge k+1;
  - `hi`/`lo` are left unchanged and `div_by_zero` = 0.
- MULT/MULTU timing is identical in both builds.

## Test plan
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001; `done` after edge k+33; `busy` high for exactly 33 cycles.
- MULT a=−3 b=5 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. MULT a=0x80000000 b=0x80000000 -> `hi`=0x40000000, `lo`=0.
- DIV a=−7 b=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU a=100 b=7 -> `lo`=14, `hi`=2.
- DIVU a=100 b=0 -> `lo`=0xFFFFFFFF, `hi`=0x64, `div_by_zero`=1 with `done`. DIV a=0x80000000 b=−1 -> `lo`=0x80000000, `hi`=0.
- Busy-period hazards:
  - A second `start` at edge k+5 is ignored.
  - `wr_hi` with `wdata`=0x1234 at edge k+10 is ignored; the final `hi` equals the product.
  - `wr_lo` in IDLE writes `lo` at once.
- Async reset:
  - Drop `rst_n` at k+12 mid-divide: all outputs go to 0 immediately, with no `done`.
  - After release, MULTU 6×7 gives `lo`=42.
  - With `ALU_MULDIV_DIV_EN` undefined, DIVU pulses `done` after k+1 with `hi`/`lo` unchanged.

Source files
------------

// File: rtl/alu_muldiv.sv
// Iterative MIPS32-style multiply/divide unit holding the HI/LO pair (shift-add multiply,
// restoring divide on magnitudes). Define ALU_MULDIV_DIV_EN to build the divider datapath.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state;
  logic               div_q;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   mag_a;
  logic [2*WIDTH:0]   acc;
  logic [CW-1:0]      cnt;

  logic               is_signed;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH:0]   mul_next;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;

  // Negating the most negative value wraps to 2^(WIDTH-1), which reads correctly as unsigned.
  assign is_signed = ~op[0];
  assign a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;

  // Upper half of acc is the running partial product (with carry bit), lower half the multiplier.
  assign mul_sum  = acc[2*WIDTH:WIDTH] + {1'b0, mag_a};
  assign mul_next = acc[0] ? ({mul_sum, acc[WIDTH-1:0]} >> 1) : (acc >> 1);
  assign prod     = acc[2*WIDTH-1:0];
  assign prod_fix = (sign_a ^ sign_b) ? -prod : prod;

`ifdef ALU_MULDIV_DIV_EN
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic             div_ge;
  logic [2*WIDTH:0] div_next;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] orig_a;

  // For divide, acc holds {remainder, dividend/quotient shift register}.
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, mag_b};
  assign div_ge    = ~div_diff[WIDTH+1];
  assign div_next  = {(div_ge ? div_diff[WIDTH:0] : div_shift), acc[WIDTH-2:0], div_ge};
  assign quot      = acc[WIDTH-1:0];
  assign rem       = acc[2*WIDTH-1:WIDTH];
  assign quot_fix  = (sign_a ^ sign_b) ? -quot : quot;
  assign rem_fix   = sign_a ? -rem : rem;
  assign orig_a    = sign_a ? -mag_a : mag_a;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_q       <= 1'b0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      mag_a       <= '0;
      acc         <= '0;
      cnt         <= '0;
`ifdef ALU_MULDIV_DIV_EN
      mag_b       <= '0;
`endif
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;

      if (!busy) begin
        if (wr_hi) hi <= wdata;
        if (wr_lo) lo <= wdata;
      end

      case (state)
        IDLE: begin
          if (start) begin
            div_q  <= op[1];
            mag_a  <= a_mag;
            sign_a <= is_signed & a[WIDTH-1];
            sign_b <= is_signed & b[WIDTH-1];
            cnt    <= '0;
            acc    <= {{(WIDTH+1){1'b0}}, (op[1] ? a_mag : b_mag)};
            busy   <= 1'b1;
`ifdef ALU_MULDIV_DIV_EN
            mag_b  <= b_mag;
            state  <= CALC;
`else
            state  <= op[1] ? FIX : CALC;
`endif
          end
        end

        CALC: begin
`ifdef ALU_MULDIV_DIV_EN
          acc <= div_q ? div_next : mul_next;
`else
          acc <= mul_next;
`endif
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end

        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (!div_q) begin
            {hi, lo} <= prod_fix;
          end
`ifdef ALU_MULDIV_DIV_EN
          else if (mag_b == '0) begin
            hi          <= orig_a;
            lo          <= '1;
            div_by_zero <= 1'b1;
          end else begin
            hi <= rem_fix;
            lo <= quot_fix;
          end
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
